// File: rtl/key_pkg.sv
// Shared definitions for the key loader: FSM state encoding, default key width,
// and the even-parity helper used by the optional parity check.
// Ports: none (package). Optional feature macro: KEY_LOADER_PARITY_EN.
package key_pkg;

  localparam int KEY_W_DEFAULT = 16;
  // Widest key the parity helper accepts; narrower keys are zero-extended.
  localparam int KEY_W_MAX     = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_e;

  // Zero-extension does not change the XOR, so any KEY_W <= KEY_W_MAX is fine.
  function automatic logic even_parity(input logic [KEY_W_MAX-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/key_shift_reg.sv
// KEY_W-bit serial-in shift register with synchronous clear, enable and direction select.
// Latency: a bit presented with en_i is visible on q_o after the next rising edge.
// Backpressure: none; the caller gates en_i. Ports: clk, rst_n, clr_i, en_i,
// msb_first_i (1: shift toward MSB so the first bit ends in q_o[KEY_W-1]), bit_i, q_o.
module key_shift_reg
  import key_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             msb_first_i,
  input  logic             bit_i,
  output logic [KEY_W-1:0] q_o
);

  logic [KEY_W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (en_i) begin
      if (msb_first_i) sr_d = {sr_q[KEY_W-2:0], bit_i};
      else             sr_d = {bit_i, sr_q[KEY_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign q_o = sr_q;

endmodule

// File: rtl/key_loader.sv
// Serial key loader for a locked netlist: shifts KEY_W bits (plus an optional even-parity
// bit when KEY_LOADER_PARITY_EN is defined), checks, then presents the key and locks.
// Latency: key_valid rises two cycles after the final accepted beat. Backpressure:
// ser_ready is high only in SHIFT; beats move on ser_valid && ser_ready, gaps stall.
// Ports: clk, rst_n (async, active-low), start, ser_valid, ser_data, ser_ready,
// key_out[KEY_W], key_valid, busy, err (constant 0 unless KEY_LOADER_PARITY_EN).
module key_loader
  import key_pkg::*;
#(
  parameter int KEY_W     = KEY_W_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

`ifdef KEY_LOADER_PARITY_EN
  localparam int BEATS = KEY_W + 1;
`else
  localparam int BEATS = KEY_W;
`endif
  // Sized to hold the full beat count of a load, so the counter never wraps.
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] KEY_BEATS = CNT_W'(KEY_W);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             sr_clr;
  logic             sr_en;
  logic             check_pass;
  logic [KEY_W-1:0] sr_key;

  assign accept = (state_q == SHIFT) && ser_valid;
  // Only the first KEY_W beats are key bits; a trailing parity beat is held separately.
  assign sr_en  = accept && (cnt_q < KEY_BEATS);

`ifdef KEY_LOADER_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign check_pass = ~(even_parity(KEY_W_MAX'(sr_key)) ^ par_q);
`else
  assign check_pass = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_clr  = 1'b0;
`ifdef KEY_LOADER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE, ERROR: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sr_clr  = 1'b1;
`ifdef KEY_LOADER_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
`ifdef KEY_LOADER_PARITY_EN
          if (cnt_q == KEY_BEATS) par_d = ser_data;
`endif
          if (cnt_q == LAST_BEAT) state_d = CHECK;
        end
      end
      CHECK:   state_d = check_pass ? DONE : ERROR;
      // DONE only leaves through reset so a loaded key cannot be replaced in the field.
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  key_shift_reg #(
    .KEY_W (KEY_W)
  ) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (sr_clr),
    .en_i        (sr_en),
    .msb_first_i (MSB_FIRST),
    .bit_i       (ser_data),
    .q_o         (sr_key)
  );

  // Outputs decode straight from state so reset clears them without waiting for an edge.
  assign ser_ready = (state_q == SHIFT);
  assign busy      = (state_q == SHIFT) || (state_q == CHECK);
  assign key_valid = (state_q == DONE);
  // Gate so partial or failed keys never reach the locked netlist.
  assign key_out   = key_valid ? sr_key : '0;
`ifdef KEY_LOADER_PARITY_EN
  assign err       = (state_q == ERROR);
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_key_loader.sv
module tb_key_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        ser_valid;
  logic        ser_data;
  logic        ser_ready_a, ser_ready_b;
  logic [15:0] key_out_a, key_out_b;
  logic        key_valid_a, key_valid_b;
  logic        busy_a, busy_b;
  logic        err_a, err_b;

`ifdef KEY_LOADER_PARITY_EN
  localparam int EXP_BEATS = 17;
`else
  localparam int EXP_BEATS = 16;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  key_loader #(.KEY_W(16), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_ready(ser_ready_a), .key_out(key_out_a), .key_valid(key_valid_a),
    .busy(busy_a), .err(err_a)
  );

  key_loader #(.KEY_W(16), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_ready(ser_ready_b), .key_out(key_out_b), .key_valid(key_valid_b),
    .busy(busy_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts accepted beats, and on each key_valid rise pops the scoreboard.
  int cyc = 0;
  int beats_a = 0, beats_b = 0;
  int last_a = 0, last_b = 0;
  logic kv_prev_a = 1'b0, kv_prev_b = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (start) begin
      beats_a = 0;
      beats_b = 0;
    end
    if (ser_valid && ser_ready_a) begin beats_a++; last_a = cyc; end
    if (ser_valid && ser_ready_b) begin beats_b++; last_b = cyc; end
    if (key_valid_a && !kv_prev_a) begin
      if (exp_a.size() == 0) begin
        chk("a_unexpected_key", {16'h0, key_out_a}, 32'hDEAD_0000);
      end else begin
        chk("a_key", {16'h0, key_out_a}, {16'h0, exp_a.pop_front()});
        chk("a_beats", beats_a, EXP_BEATS);
        chk("a_latency", cyc - last_a, 2);
        chk("a_busy_done", {31'h0, busy_a}, 0);
      end
    end
    if (key_valid_b && !kv_prev_b) begin
      if (exp_b.size() == 0) begin
        chk("b_unexpected_key", {16'h0, key_out_b}, 32'hDEAD_0000);
      end else begin
        chk("b_key", {16'h0, key_out_b}, {16'h0, exp_b.pop_front()});
        chk("b_beats", beats_b, EXP_BEATS);
        chk("b_latency", cyc - last_b, 2);
      end
    end
    kv_prev_a = key_valid_a;
    kv_prev_b = key_valid_b;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // gappy=1 drives ser_valid 1,0,0,1,... with junk data during the gaps.
  task automatic send_key(input logic [15:0] k, input logic par, input bit gappy);
    for (int i = 15; i >= 0; i--) begin
      ser_valid = 1'b1;
      ser_data  = k[i];
      @(posedge clk); #1;
      if (gappy && i != 0) begin
        ser_valid = 1'b0;
        ser_data  = ~k[i];
        repeat (2) begin @(posedge clk); #1; end
      end
    end
`ifdef KEY_LOADER_PARITY_EN
    ser_valid = 1'b1;
    ser_data  = par;
    @(posedge clk); #1;
`else
    ser_data  = par;
`endif
    ser_valid = 1'b0;
    ser_data  = 1'b0;
  endtask

  task automatic wait_kv(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (key_valid_a) seen = 1'b1;
    end
    chk(name, {31'h0, seen}, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_key_out_a", {16'h0, key_out_a}, 0);
    chk("rst_key_out_b", {16'h0, key_out_b}, 0);
    chk("rst_key_valid", {31'h0, key_valid_a}, 0);
    chk("rst_busy", {31'h0, busy_a}, 0);
    chk("rst_ser_ready", {31'h0, ser_ready_a}, 0);
    chk("rst_err", {31'h0, err_a}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ser_ready", {31'h0, ser_ready_a}, 0);

    // Back-to-back 0xA5C3; LSB-first instance sees the bit-reversed key.
    pulse_start();
    chk("shift_busy", {31'h0, busy_a}, 1);
    chk("shift_ser_ready", {31'h0, ser_ready_a}, 1);
    exp_a.push_back(16'hA5C3);
    exp_b.push_back(16'hC3A5);
    send_key(16'hA5C3, 1'b0, 1'b0);
    wait_kv("t1_done");
    chk("t1_ser_ready_done", {31'h0, ser_ready_a}, 0);
    chk("t1_err", {31'h0, err_a}, 0);

    // 0x0001 with ser_valid gaps.
    do_reset();
    pulse_start();
    exp_a.push_back(16'h0001);
    exp_b.push_back(16'h8000);
    send_key(16'h0001, 1'b1, 1'b1);
    wait_kv("t2_done");

    // Reset after 8 beats discards the partial key.
    do_reset();
    pulse_start();
    for (int i = 15; i >= 8; i--) begin
      ser_valid = 1'b1;
      ser_data  = 1'(16'h1234 >> i);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_key_out", {16'h0, key_out_a}, 0);
    chk("midrst_key_valid", {31'h0, key_valid_a}, 0);
    chk("midrst_busy", {31'h0, busy_a}, 0);
    chk("midrst_ser_ready", {31'h0, ser_ready_a}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    ser_valid = 1'b0;
    chk("postrst_busy", {31'h0, busy_a}, 0);
    chk("postrst_key_valid", {31'h0, key_valid_a}, 0);

    // Full 0x1234 load, then DONE must ignore start and further beats.
    pulse_start();
    exp_a.push_back(16'h1234);
    exp_b.push_back(16'h2C48);
    send_key(16'h1234, 1'b1, 1'b0);
    wait_kv("t4_done");
    pulse_start();
    ser_valid = 1'b1;
    ser_data  = 1'b1;
    repeat (17) begin @(posedge clk); #1; end
    ser_valid = 1'b0;
    chk("sticky_key_a", {16'h0, key_out_a}, 32'h1234);
    chk("sticky_key_b", {16'h0, key_out_b}, 32'h2C48);
    chk("sticky_key_valid", {31'h0, key_valid_a}, 1);
    chk("sticky_ser_ready", {31'h0, ser_ready_a}, 0);
    chk("sticky_busy", {31'h0, busy_a}, 0);

`ifdef KEY_LOADER_PARITY_EN
    // Bad parity -> ERROR, then a retry with correct parity succeeds.
    do_reset();
    pulse_start();
    send_key(16'h00FF, 1'b1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("par_err", {31'h0, err_a}, 1);
    chk("par_key_out", {16'h0, key_out_a}, 0);
    chk("par_key_valid", {31'h0, key_valid_a}, 0);
    chk("par_busy", {31'h0, busy_a}, 0);
    pulse_start();
    chk("par_err_cleared", {31'h0, err_a}, 0);
    exp_a.push_back(16'h00FF);
    exp_b.push_back(16'hFF00);
    send_key(16'h00FF, 1'b0, 1'b0);
    wait_kv("par_retry_done");
    chk("par_retry_err", {31'h0, err_a}, 0);
`else
    chk("nopar_err_const", {31'h0, err_a | err_b}, 0);
`endif

    repeat (3) begin @(posedge clk); #1; end
    chk("sb_a_empty", exp_a.size(), 0);
    chk("sb_b_empty", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 Parameter KEY_W, default 16, SHALL set the key width delivered to the locked netlist (keyinput0..keyinput15 for the 16-key circuit).
REQ-002 Parameter MSB_FIRST, default 1, SHALL select serial order: 1 = first accepted bit lands in key_out[KEY_W-1]; 0 = first bit lands in key_out[0].
REQ-003 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load.
- ser_valid  in  1  serial source has a bit on ser_data.
- ser_data  in  1  serial key bit.
- ser_ready  out  1  loader accepts a bit this cycle.
- key_out  out  KEY_W  key vector to the locked netlist; key_out[i] drives keyinput<i>.
- key_valid  out  1  key_out holds a complete, accepted key.
- busy  out  1  load in progress.
- err  out  1  last load failed its check (KEY_PARITY_EN only; otherwise tied 0).

Function
REQ-004 The FSM SHALL have states IDLE, SHIFT, CHECK, DONE, ERROR.
REQ-005 IDLE: ser_ready=0, busy=0; start=1 -> SHIFT, bit counter cleared, shift register cleared.
REQ-006 SHIFT: ser_ready=1, busy=1; a beat is accepted only when ser_valid && ser_ready; gaps in ser_valid stall without losing accepted bits.
REQ-007 The bit counter SHALL be ceil(log2(KEY_W+1)) bits wide and increment once per accepted beat; it SHALL never exceed the beat count of the current load.
REQ-008 On the beat that completes the load (KEY_W beats, or KEY_W+1 with parity), the FSM SHALL go to CHECK on the next edge.
REQ-009 CHECK SHALL last exactly one cycle (ser_ready=0, busy=1), then go to DONE on pass or ERROR on fail.
REQ-010 DONE: key_out = shifted key, key_valid=1, busy=0, ser_ready=0; key_valid rises two cycles after the final accepted beat.
REQ-011 DONE SHALL be sticky: start and ser_valid are ignored until rst_n asserts (key cannot be overwritten in-field).
REQ-012 While key_valid=0, key_out SHALL be all zeros; partial keys SHALL never appear on key_out.
REQ-013 ERROR: err=1, key_valid=0, key_out=0, busy=0; start=1 -> SHIFT, err cleared on the same edge.
REQ-014 start while in SHIFT or CHECK SHALL be ignored.
REQ-015 ser_valid while not in SHIFT SHALL be ignored and not consumed.

Reset
REQ-016 rst_n=0 SHALL immediately, asynchronously force IDLE, counter=0, shift register=0, key_out=0, key_valid=0, busy=0, ser_ready=0, err=0.
REQ-017 Reset mid-SHIFT or in DONE SHALL discard the key; a fresh start is required after release.

Configuration
REQ-018 Macro KEY_LOADER_PARITY_EN defined: the load SHALL take KEY_W+1 beats; beat KEY_W+1 is an even-parity bit over the key; CHECK passes when XOR of all KEY_W+1 bits is 0, else ERROR.
REQ-019 Macro undefined: the load SHALL take KEY_W beats, CHECK always passes, ERROR is unreachable, err is constant 0.

Structure
REQ-020 A shared package key_pkg SHALL hold the FSM state enum, KEY_W default, and the parity helper function.
REQ-021 One sub-module key_shift_reg (KEY_W-bit shift register with enable, direction select, clear) SHALL be instantiated; FSM and counter stay in key_loader.

Verification
REQ-022 MSB_FIRST=1, no parity: start, 16 back-to-back beats of 0xA5C3 MSB first -> key_out=16'hA5C3, key_valid=1 two cycles after beat 16, busy low.
REQ-023 MSB_FIRST=0: same bit stream as REQ-022 -> key_out=16'hC3A5 with each key_out[i] equal to beat i+1, i.e. bit-reversed 0xA5C3.
REQ-024 ser_valid toggled 1,0,0,1,... across a 0x0001 load -> key_out=16'h0001, exactly 16 accepted beats counted, no dropped or duplicate bits.
REQ-025 KEY_LOADER_PARITY_EN: key 0x00FF plus parity 1 -> ERROR, err=1, key_out=0; retry start with parity 0 -> DONE, key_out=16'h00FF, err=0.
REQ-026 rst_n pulsed low after beat 8 -> all outputs 0 within the reset cycle; start in DONE after a valid load of 0x1234 -> key_out stays 16'h1234, ser_ready stays 0.
